// File: rtl/spi_slave_core.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_core
// Description : SPI target engine. It oversamples the pads, deserialises MOSI
//               into a one-entry RX buffer and serialises a TX byte stream
//               onto MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_core #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic                  udr_o,
    output logic                  abort_o,
    input  logic                  spi_sck_i,
    input  logic                  spi_nss_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_en_o
);

    localparam int                 c_cnt_w    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_nss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_nss_d;

    logic [0:0]             r_state;
    logic                   r_cpol;
    logic                   r_cpha;
    logic                   r_lsb;
    logic [c_cnt_w-1:0]     r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_tx_shift;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_tx_ready;
    logic                   r_udr;
    logic                   r_ovf;
    logic                   r_abort;
    logic                   r_miso;

    logic                   w_sck;
    logic                   w_nss;
    logic                   w_mosi;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_drive;
    logic                   w_nss_fall;
    logic                   w_nss_rise;
    logic                   w_cnt_wrap;
    logic                   w_rx_accept;
    logic [DATA_WIDTH-1:0]  w_fetch_byte;
    logic [DATA_WIDTH-1:0]  w_rx_next;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] b, input logic lsb);
        return lsb ? b[0] : b[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] b,
                                                        input logic lsb);
        return lsb ? (b >> 1) : (b << 1);
    endfunction

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_nss  = r_nss_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Edges are classified against the mode latched at frame start.
    assign w_lead     = (r_sck_d == r_cpol) && (w_sck != r_cpol);
    assign w_trail    = (r_sck_d != r_cpol) && (w_sck == r_cpol);
    assign w_sample   = r_cpha ? w_trail : w_lead;
    assign w_drive    = r_cpha ? w_lead : w_trail;
    assign w_nss_fall = r_nss_d & ~w_nss;
    assign w_nss_rise = ~r_nss_d & w_nss;

    assign w_cnt_wrap   = (r_bit_cnt == c_cnt_max);
    assign w_rx_accept  = ~r_rx_valid | rx_ready_i;
    assign w_fetch_byte = tx_valid_i ? tx_data_i : IDLE_BYTE;
    assign w_rx_next    = r_lsb ? {w_mosi, r_rx_shift[DATA_WIDTH-1:1]}
                                : {r_rx_shift[DATA_WIDTH-2:0], w_mosi};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sck_sync  <= '0;
            r_nss_sync  <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_nss_d     <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], spi_nss_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            r_sck_d     <= w_sck;
            r_nss_d     <= w_nss;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_st_idle;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_bit_cnt  <= c_cnt_zero;
            r_rx_shift <= '0;
            r_tx_shift <= IDLE_BYTE;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_udr      <= 1'b0;
            r_ovf      <= 1'b0;
            r_abort    <= 1'b0;
            r_miso     <= IDLE_BYTE[DATA_WIDTH-1];
        end else begin
            r_tx_ready <= 1'b0;
            r_udr      <= 1'b0;
            r_ovf      <= 1'b0;
            r_abort    <= 1'b0;
            if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end

            if (!en_i) begin
                if ((r_state == c_st_shift) && (r_bit_cnt != c_cnt_zero)) begin
                    r_abort <= 1'b1;
                end
                r_state    <= c_st_idle;
                r_bit_cnt  <= c_cnt_zero;
                r_rx_valid <= 1'b0;
                r_rx_data  <= '0;
                r_miso     <= IDLE_BYTE[DATA_WIDTH-1];
            end else if (r_state == c_st_idle) begin
                r_cpol <= cpol_i;
                r_cpha <= cpha_i;
                r_lsb  <= lsb_i;
                if (w_nss_fall) begin
                    r_state    <= c_st_shift;
                    r_tx_ready <= tx_valid_i;
                    r_udr      <= ~tx_valid_i;
                    // CPHA=0 must present its first bit before the first SCK edge.
                    if (cpha_i) begin
                        r_tx_shift <= w_fetch_byte;
                    end else begin
                        r_miso     <= first_bit(w_fetch_byte, lsb_i);
                        r_tx_shift <= shift_out(w_fetch_byte, lsb_i);
                    end
                end
            end else if (w_nss_rise) begin
                if (r_bit_cnt != c_cnt_zero) begin
                    r_abort <= 1'b1;
                end
                r_state   <= c_st_idle;
                r_bit_cnt <= c_cnt_zero;
                r_miso    <= IDLE_BYTE[DATA_WIDTH-1];
            end else if (w_sample) begin
                r_rx_shift <= w_rx_next;
                if (w_cnt_wrap) begin
                    // Next byte is loaded unshifted; the following drive edge presents its first bit.
                    r_bit_cnt  <= c_cnt_zero;
                    r_tx_ready <= tx_valid_i;
                    r_udr      <= ~tx_valid_i;
                    r_tx_shift <= w_fetch_byte;
                    if (w_rx_accept) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_cnt_one;
                end
            end else if (w_drive) begin
                r_miso     <= first_bit(r_tx_shift, r_lsb);
                r_tx_shift <= shift_out(r_tx_shift, r_lsb);
            end
        end
    end

    assign tx_ready_o    = r_tx_ready;
    assign rx_valid_o    = r_rx_valid;
    assign rx_data_o     = r_rx_data;
    assign busy_o        = (r_state == c_st_shift);
    assign ovf_o         = r_ovf;
    assign udr_o         = r_udr;
    assign abort_o       = r_abort;
    assign spi_miso_o    = r_miso;
    assign spi_miso_en_o = (r_state == c_st_shift);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_core
// Description : Randomised scoreboard bench for spi_slave_core with an SPI
//               master bus model and a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_core;

    localparam int          c_half    = 80;
    localparam logic [15:0] c_rst_vec = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk_i = 1'b0;
    logic       rst_i, en_i, cpol_i, cpha_i, lsb_i;
    logic       tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
    logic [7:0] tx_data_i, rx_data_o;
    logic       busy_o, ovf_o, udr_o, abort_o;
    logic       spi_sck_i, spi_nss_i, spi_mosi_i, spi_miso_o, spi_miso_en_o;

    int n_cmp = 0;
    int n_err = 0;
    int obs_txpop = 0, obs_udr = 0, obs_ovf = 0, obs_abort = 0;
    int exp_txpop = 0, exp_udr = 0, exp_ovf = 0, exp_abort = 0;
    logic       model_full = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] model_tx[$];
    logic [7:0] exp_miso[$];
    logic [7:0] obs_miso[$];
    logic [7:0] exp_rx[$];
    logic [7:0] fr_mosi[$];

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_i(lsb_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
        .busy_o(busy_o), .ovf_o(ovf_o), .udr_o(udr_o), .abort_o(abort_o),
        .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] outvec();
        return {tx_ready_o, rx_valid_o, rx_data_o, busy_o, ovf_o, udr_o, abort_o,
                spi_miso_o, spi_miso_en_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_txpop"}, obs_txpop, exp_txpop);
        check({tag, "_udr"}, obs_udr, exp_udr);
        check({tag, "_ovf"}, obs_ovf, exp_ovf);
        check({tag, "_abort"}, obs_abort, exp_abort);
    endtask

    // TX source: a FIFO head that pops on the ready strobe.
    initial begin
        logic [7:0] tmp;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        forever begin
            @(posedge clk_i);
            #1;
            if (tx_ready_o && tx_q.size() > 0) tmp = tx_q.pop_front();
            tx_valid_i = (tx_q.size() > 0);
            tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 8'($urandom);
        end
    end

    // Monitor: pulse counters, RX handshakes and captured MISO bytes.
    initial begin
        forever begin
            @(negedge clk_i);
            if (tx_ready_o) obs_txpop++;
            if (udr_o) obs_udr++;
            if (ovf_o) obs_ovf++;
            if (abort_o) obs_abort++;
            if (rx_valid_o && rx_ready_i) begin
                if (exp_rx.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                else check("rx_data", rx_data_o, exp_rx.pop_front());
            end
            while (obs_miso.size() > 0) begin
                if (exp_miso.size() == 0) check("miso_unexpected", obs_miso.pop_front(), 32'hFFFF);
                else check("miso_byte", obs_miso.pop_front(), exp_miso.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic push_tx(input logic [7:0] b);
        tx_q.push_back(b);
        model_tx.push_back(b);
    endtask

    task automatic set_mode(input logic cp, input logic ch, input logic lb);
        cpol_i = cp; cpha_i = ch; lsb_i = lb;
        spi_sck_i = cp;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    // kind 0: NSS release, 1: en_i drop, 2: rst_i pulse; applied after nbits bits.
    task automatic run_frame(input int nbits, input int kind, input string tag);
        int         nfull;
        logic [7:0] cur;
        logic       bits[$];
        nfull = nbits / 8;
        for (int k = 0; k <= nfull; k++) begin
            logic [7:0] b;
            if (model_tx.size() > 0) begin b = model_tx.pop_front(); exp_txpop++; end
            else begin b = 8'hFF; exp_udr++; end
            if (k < nfull) exp_miso.push_back(b);
        end
        for (int k = 0; k < nfull; k++) begin
            if (rx_ready_i || !model_full) begin
                exp_rx.push_back(fr_mosi[k]);
                if (!rx_ready_i) model_full = 1'b1;
            end else begin
                exp_ovf++;
            end
        end
        if (kind != 2 && (nbits % 8) != 0) exp_abort++;
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] mb;
            int         j;
            mb = ((i / 8) < fr_mosi.size()) ? fr_mosi[i / 8] : 8'h00;
            j  = i % 8;
            bits.push_back(lsb_i ? mb[j] : mb[7 - j]);
        end

        cur = 8'h00;
        spi_nss_i = 1'b0;
        if (!cpha_i && nbits > 0) spi_mosi_i = bits[0];
        #(c_half);
        check({tag, "_busy_in_frame"}, {busy_o, spi_miso_en_o}, 2'b11);
        for (int i = 0; i < nbits; i++) begin
            int   j;
            logic m;
            j = i % 8;
            if (!cpha_i) begin
                m = spi_miso_o;
                spi_sck_i = ~cpol_i;
                #(c_half);
                spi_sck_i = cpol_i;
                if (i + 1 < nbits) spi_mosi_i = bits[i + 1];
                #(c_half);
            end else begin
                spi_sck_i  = ~cpol_i;
                spi_mosi_i = bits[i];
                #(c_half);
                m = spi_miso_o;
                spi_sck_i = cpol_i;
                #(c_half);
            end
            if (lsb_i) cur[j] = m; else cur[7 - j] = m;
            if (j == 7) obs_miso.push_back(cur);
        end
        #(c_half);
        case (kind)
            1: begin
                en_i = 1'b0;
                repeat (6) @(posedge clk_i);
                #1;
                check({tag, "_en_drop_outputs"}, outvec(), c_rst_vec);
                spi_nss_i = 1'b1;
                repeat (4) @(posedge clk_i);
                #1;
                en_i = 1'b1;
            end
            2: begin
                rst_i = 1'b1;
                spi_nss_i = 1'b1;
                repeat (3) @(posedge clk_i);
                #1;
                check({tag, "_rst_held_outputs"}, outvec(), c_rst_vec);
                rst_i = 1'b0;
                repeat (4) @(posedge clk_i);
                #1;
                check({tag, "_rst_released_outputs"}, outvec(), c_rst_vec);
            end
            default: spi_nss_i = 1'b1;
        endcase
        repeat (12) @(posedge clk_i);
        #1;
        check({tag, "_idle_after"}, {busy_o, spi_miso_en_o}, 2'b00);
        check_counts(tag);
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0;
        rx_ready_i = 1'b1; spi_sck_i = 1'b0; spi_nss_i = 1'b1; spi_mosi_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_held", outvec(), c_rst_vec);
        rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("reset_released", outvec(), c_rst_vec);

        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'hA5);
        fr_mosi = '{8'h3C};
        repeat (3) @(posedge clk_i);
        #1;
        run_frame(8, 0, "mode0_msb");

        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1);
            push_tx(8'($urandom));
            push_tx(8'($urandom));
            fr_mosi = '{8'h81, 8'h7E};
            repeat (3) @(posedge clk_i);
            #1;
            run_frame(16, 0, "mode_lsb");
        end

        begin
            logic [7:0] b0;
            set_mode(1'b0, 1'b0, 1'b0);
            b0 = 8'($urandom);
            fr_mosi = '{b0, 8'($urandom)};
            push_tx(8'h5A); push_tx(8'hC3);
            rx_ready_i = 1'b0;
            repeat (3) @(posedge clk_i);
            #1;
            run_frame(16, 0, "ovf");
            check("ovf_rx_valid_held", rx_valid_o, 1'b1);
            check("ovf_rx_data_kept", rx_data_o, b0);
            rx_ready_i = 1'b1;
            model_full = 1'b0;
            repeat (4) @(posedge clk_i);
            #1;
            check("ovf_drained", rx_valid_o, 1'b0);
        end

        set_mode(1'b1, 1'b1, 1'b0);
        fr_mosi = '{8'($urandom)};
        run_frame(8, 0, "udr");

        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'($urandom));
        fr_mosi = '{8'($urandom)};
        repeat (3) @(posedge clk_i);
        #1;
        run_frame(5, 0, "abort");
        fr_mosi = '{8'($urandom)};
        push_tx(8'($urandom));
        repeat (3) @(posedge clk_i);
        #1;
        run_frame(8, 0, "after_abort");

        fr_mosi = '{8'($urandom)};
        run_frame(4, 2, "rst_mid");
        fr_mosi = '{8'($urandom)};
        run_frame(8, 0, "after_rst");

        set_mode(1'b0, 1'b1, 1'b1);
        fr_mosi = '{8'($urandom)};
        run_frame(3, 1, "en_drop");
        fr_mosi = '{8'($urandom)};
        push_tx(8'($urandom));
        repeat (3) @(posedge clk_i);
        #1;
        run_frame(8, 0, "after_en");

        for (int it = 0; it < 12; it++) begin
            int nbytes, ntx, nbits;
            set_mode(1'($urandom), 1'($urandom), 1'($urandom));
            nbytes = $urandom_range(1, 3);
            ntx    = $urandom_range(0, 3);
            for (int k = 0; k < ntx; k++) push_tx(8'($urandom));
            fr_mosi.delete();
            for (int k = 0; k < 4; k++) fr_mosi.push_back(8'($urandom));
            nbits = nbytes * 8 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
            repeat (3) @(posedge clk_i);
            #1;
            run_frame(nbits, 0, "random");
        end

        for (int w = 0; w < 200; w++) begin
            if (exp_rx.size() == 0 && exp_miso.size() == 0) break;
            @(posedge clk_i);
        end
        #1;
        check("rx_leftover", exp_rx.size(), 0);
        check("miso_leftover", exp_miso.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
